// File: rtl/sd_block_read_scheduler.sv
// sd_block_read_scheduler: round-robin owner of a shared CMD17 single-block read path for two requesters.
// Optional macro SD_READ_RETRY_EN: up to two silent reissues of CMD17 before ERR is reported.
module sd_block_read_scheduler #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000,
    parameter bit          BYTE_ADDR      = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req0,
    input  logic [31:0] i_addr0,
    input  logic        i_req1,
    input  logic [31:0] i_addr1,
    output logic [1:0]  o_grant,
    output logic        o_done0,
    output logic        o_done1,
    output logic        o_err0,
    output logic        o_err1,
    output logic        o_cmd_send,
    output logic [5:0]  o_cmd_index,
    output logic [31:0] o_cmd_arg,
    input  logic        i_cmd_done,
    input  logic [7:0]  i_cmd_r1,
    output logic        o_rx_start,
    input  logic        i_rx_finish
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_R1, S_RECEIVE, S_FIN, S_FAIL} state_t;
    state_t      r_state, w_next;
    logic [1:0]  r_grant;
    logic [31:0] r_arg;
    logic        r_ptr;
    logic [23:0] r_cnt;
    logic        w_any, w_sel, w_tmo, w_retry;
    logic [31:0] w_addr;
    assign w_any  = i_req0 | i_req1;
    assign w_sel  = (i_req0 & i_req1) ? ~r_ptr : i_req1;
    assign w_addr = w_sel ? i_addr1 : i_addr0;
    assign w_tmo  = r_cnt >= TIMEOUT_CYCLES - 24'd1;
`ifdef SD_READ_RETRY_EN
    logic [1:0] r_retry;
    assign w_retry = r_retry != 2'd2;
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_retry <= 2'd0;
        else if (r_state == S_IDLE && w_any)
            r_retry <= 2'd0;
        else if (r_state == S_FAIL && w_retry)
            r_retry <= r_retry + 2'd1;
    end
`else
    assign w_retry = 1'b0;
`endif
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = w_any ? S_ISSUE : S_IDLE;
            S_ISSUE:   w_next = S_WAIT_R1;
            S_WAIT_R1: w_next = i_cmd_done ? ((i_cmd_r1 == 8'h00) ? S_RECEIVE : S_FAIL) : (w_tmo ? S_FAIL : S_WAIT_R1);
            S_RECEIVE: w_next = i_rx_finish ? S_FIN : (w_tmo ? S_FAIL : S_RECEIVE);
            S_FIN:     w_next = S_IDLE;
            S_FAIL:    w_next = w_retry ? S_ISSUE : S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_grant <= 2'b00;
            r_arg   <= 32'd0;
            r_ptr   <= 1'b1;
            r_cnt   <= 24'd0;
        end else begin
            if (r_state == S_IDLE && w_any) begin
                r_grant <= w_sel ? 2'b10 : 2'b01;
                r_arg   <= BYTE_ADDR ? {w_addr[22:0], 9'd0} : w_addr;
                r_ptr   <= w_sel;
            end
            if (r_state == S_FIN || (r_state == S_FAIL && !w_retry))
                r_grant <= 2'b00;
            // counter restarts for each phase and saturates rather than wrapping
            if (r_state == S_ISSUE || (r_state == S_WAIT_R1 && i_cmd_done))
                r_cnt <= 24'd0;
            else if ((r_state == S_WAIT_R1 || r_state == S_RECEIVE) && r_cnt != 24'hFFFFFF)
                r_cnt <= r_cnt + 24'd1;
        end
    end
    always_comb begin
        o_grant     = r_grant;
        o_cmd_send  = r_state == S_ISSUE;
        o_rx_start  = r_state == S_RECEIVE;
        o_done0     = r_state == S_FIN && r_grant[0];
        o_done1     = r_state == S_FIN && r_grant[1];
        o_err0      = r_state == S_FAIL && !w_retry && r_grant[0];
        o_err1      = r_state == S_FAIL && !w_retry && r_grant[1];
        o_cmd_index = (r_grant != 2'b00) ? 6'd17 : 6'd0;
        o_cmd_arg   = r_arg;
    end
endmodule

// File: tb/tb_sd_block_read_scheduler.sv
// tb_sd_block_read_scheduler: directed checks of arbitration, CMD17 sequencing, timeouts and reset.
module tb_sd_block_read_scheduler;
    localparam logic [23:0] TMO = 24'd100;
`ifdef SD_READ_RETRY_EN
    localparam int NSEND = 3;
`else
    localparam int NSEND = 1;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0, cmd_done = 1'b0, rx_finish = 1'b0;
    logic [31:0] addr0 = 32'd0, addr1 = 32'd0;
    logic [7:0] cmd_r1 = 8'd0;
    logic [1:0] grant, b_grant;
    logic done0, done1, err0, err1, cmd_send, rx_start;
    logic b_done0, b_done1, b_err0, b_err1, b_cmd_send, b_rx_start;
    logic [5:0] cmd_index, b_cmd_index;
    logic [31:0] cmd_arg, b_cmd_arg;
    int n_chk = 0, n_pass = 0;
    int n_send = 0, n_done0 = 0, n_done1 = 0, n_err0 = 0, n_rx = 0, n_both = 0;
    int s_send, s_done0, s_err0, s_rx, n;
    bit ok;
    logic [1:0] g [3];

    sd_block_read_scheduler #(.TIMEOUT_CYCLES(TMO), .BYTE_ADDR(1'b1)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_req0(req0), .i_addr0(addr0), .i_req1(req1), .i_addr1(addr1),
        .o_grant(grant), .o_done0(done0), .o_done1(done1), .o_err0(err0), .o_err1(err1),
        .o_cmd_send(cmd_send), .o_cmd_index(cmd_index), .o_cmd_arg(cmd_arg),
        .i_cmd_done(cmd_done), .i_cmd_r1(cmd_r1), .o_rx_start(rx_start), .i_rx_finish(rx_finish));

    sd_block_read_scheduler #(.TIMEOUT_CYCLES(TMO), .BYTE_ADDR(1'b0)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_req0(req0), .i_addr0(addr0), .i_req1(req1), .i_addr1(addr1),
        .o_grant(b_grant), .o_done0(b_done0), .o_done1(b_done1), .o_err0(b_err0), .o_err1(b_err1),
        .o_cmd_send(b_cmd_send), .o_cmd_index(b_cmd_index), .o_cmd_arg(b_cmd_arg),
        .i_cmd_done(cmd_done), .i_cmd_r1(cmd_r1), .o_rx_start(b_rx_start), .i_rx_finish(rx_finish));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_send  += int'(cmd_send);
        n_done0 += int'(done0);
        n_done1 += int'(done1);
        n_err0  += int'(err0);
        n_rx    += int'(rx_start);
        if ((done0 | done1) & (err0 | err1)) n_both++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
        else n_pass++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_send(output bit found);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (cmd_send) found = 1'b1;
            else tick;
        end
    endtask

    task automatic pulse_cmd(input logic [7:0] r1);
        cmd_done = 1'b1;
        cmd_r1   = r1;
        tick;
        cmd_done = 1'b0;
        cmd_r1   = 8'd0;
    endtask

    task automatic pulse_fin;
        rx_finish = 1'b1;
        tick;
        rx_finish = 1'b0;
    endtask

    initial begin
        tick;
        tick;
        chk("rst_grant", grant, 2'b00);
        chk("rst_arg", cmd_arg, 32'd0);
        chk("rst_send", cmd_send, 1'b0);
        chk("rst_rx", rx_start, 1'b0);
        rst = 1'b0;
        // single OK transfer from requester 0
        s_send = n_send; s_done0 = n_done0;
        req0 = 1'b1; addr0 = 32'd5;
        tick;
        chk("t1_grant", grant, 2'b01);
        chk("t1_send", cmd_send, 1'b1);
        chk("t1_arg", cmd_arg, 32'h00000A00);
        chk("t1_index", cmd_index, 6'd17);
        tick;
        repeat (9) tick;
        pulse_cmd(8'h00);
        chk("t1_rx_on", rx_start, 1'b1);
        n = 0;
        repeat (50) begin
            if (!rx_start) n++;
            tick;
        end
        chk("t1_rx_hold", n, 0);
        pulse_fin;
        chk("t1_done0", done0, 1'b1);
        chk("t1_err0", err0, 1'b0);
        chk("t1_rx_off", rx_start, 1'b0);
        req0 = 1'b0;
        tick;
        chk("t1_grant_drop", grant, 2'b00);
        chk("t1_nsend", n_send - s_send, 1);
        chk("t1_ndone", n_done0 - s_done0, 1);
        // both requesting from reset alternate 01,10,01
        rst = 1'b1;
        tick;
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1; addr1 = 32'd7;
        for (int k = 0; k < 3; k++) begin
            wait_send(ok);
            chk("t2_send", ok, 1'b1);
            g[k] = grant;
            tick;
            pulse_cmd(8'h00);
            repeat (3) tick;
            pulse_fin;
            if (k == 2) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            tick;
        end
        chk("t2_grant0", g[0], 2'b01);
        chk("t2_grant1", g[1], 2'b10);
        chk("t2_grant2", g[2], 2'b01);
        // R1 error
        s_send = n_send; s_err0 = n_err0; s_rx = n_rx;
        req0 = 1'b1; addr0 = 32'd1;
        for (int a = 0; a < NSEND; a++) begin
            wait_send(ok);
            chk("t3_send", ok, 1'b1);
            tick;
            pulse_cmd(8'h04);
            chk("t3_err0", err0, (a == NSEND - 1) ? 1'b1 : 1'b0);
            chk("t3_done0", done0, 1'b0);
        end
        req0 = 1'b0;
        tick;
        chk("t3_grant_drop", grant, 2'b00);
        chk("t3_nsend", n_send - s_send, NSEND);
        chk("t3_nerr", n_err0 - s_err0, 1);
        chk("t3_no_rx", n_rx - s_rx, 0);
        // receive timeout
        req0 = 1'b1;
        wait_send(ok);
        chk("t4_send", ok, 1'b1);
        tick;
        pulse_cmd(8'h00);
        n = 0;
        while (!err0 && n < 200) begin
            tick;
            n++;
        end
        chk("t4_tmo_cycles", n, 100);
        chk("t4_rx_off", rx_start, 1'b0);
        chk("t4_done0", done0, 1'b0);
        req0 = 1'b0;
        tick;
        // reset while receiving
        req0 = 1'b1;
        wait_send(ok);
        tick;
        pulse_cmd(8'h00);
        repeat (5) tick;
        s_done0 = n_done0;
        rst = 1'b1; req0 = 1'b0;
        tick;
        chk("t5_grant", grant, 2'b00);
        chk("t5_rx", rx_start, 1'b0);
        chk("t5_send", cmd_send, 1'b0);
        chk("t5_arg", cmd_arg, 32'd0);
        chk("t5_index", cmd_index, 6'd0);
        chk("t5_doneerr", {done0, done1, err0, err1}, 4'd0);
        rst = 1'b0;
        req1 = 1'b1; addr1 = 32'hFFFFFFFF;
        wait_send(ok);
        chk("t5_send1", ok, 1'b1);
        chk("t5_grant1", grant, 2'b10);
        chk("t5_arg_byte", cmd_arg, 32'hFFFFFE00);
        chk("t5_arg_block", b_cmd_arg, 32'hFFFFFFFF);
        tick;
        pulse_cmd(8'h00);
        tick;
        pulse_fin;
        chk("t5_done1", done1, 1'b1);
        chk("t5_done0", done0, 1'b0);
        req1 = 1'b0;
        tick;
        chk("t5_no_stale", n_done0 - s_done0, 0);
        // CMD_DONE and RX_FINISH on their timeout cycles both win
        req0 = 1'b1;
        wait_send(ok);
        chk("t6_send", ok, 1'b1);
        tick;
        repeat (99) tick;
        pulse_cmd(8'h00);
        chk("t6_r1_edge", rx_start, 1'b1);
        repeat (99) tick;
        pulse_fin;
        chk("t6_done0", done0, 1'b1);
        chk("t6_err0", err0, 1'b0);
        req0 = 1'b0;
        tick;
        chk("no_overlap", n_both, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
